// File: rtl/flops_pipe_valid.sv
// LANES x WIDTH valid/data register pipeline, DEPTH stages; FLOPS_PIPE_CNT_EN adds beat_count.
// Latency DEPTH cycles with ready_in high; full throughput, bubbles never stored.
// Backpressure: ready_out = combinational advance chain from ready_in; empty stages absorb stalls.
module flops_pipe_valid #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 2
) (
  input  logic                   clk_8f,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [LANES-1:0]       valid_in,
  input  logic [LANES*WIDTH-1:0] data_in,
  output logic                   ready_out,
  output logic [LANES-1:0]       valid_out,
  output logic [LANES*WIDTH-1:0] data_out,
  input  logic                   ready_in
`ifdef FLOPS_PIPE_CNT_EN
  ,
  output logic [15:0]            beat_count
`endif
);

  logic [DEPTH-1:0]       occ;
  logic [DEPTH-1:0]       adv;
  logic [LANES-1:0]       lv  [DEPTH];
  logic [LANES*WIDTH-1:0] dat [DEPTH];

  // adv[k] is high when any stage from k to the output is empty, or the output drains.
  always_comb begin : adv_chain
    logic run;
    run = ready_in;
    adv = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      run    = run | ~occ[k];
      adv[k] = run;
    end
  end

  assign ready_out = adv[0];
  assign valid_out = occ[DEPTH-1] ? lv[DEPTH-1] : '0;
  assign data_out  = dat[DEPTH-1];

  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      occ <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        lv[k]  <= '0;
        dat[k] <= '0;
      end
    end else if (flush) begin
      // Data registers keep their contents; only occupancy and lane valids are dropped.
      occ <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        lv[k] <= '0;
      end
    end else begin
      if (adv[0]) begin
        occ[0] <= |valid_in;
        lv[0]  <= valid_in;
        dat[0] <= data_in;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k]) begin
          occ[k] <= occ[k-1];
          lv[k]  <= lv[k-1];
          dat[k] <= dat[k-1];
        end
      end
    end
  end

`ifdef FLOPS_PIPE_CNT_EN
  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      beat_count <= '0;
    end else if (|valid_out && ready_in) begin
      beat_count <= beat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_flops_pipe_valid.sv
// Directed bench for flops_pipe_valid: scoreboard on the default instance, direct checks on a DEPTH=4 instance.
module tb_flops_pipe_valid;

  logic        clk_8f = 1'b0;
  logic        reset;
  logic        flush;
  logic [3:0]  valid_in;
  logic [31:0] data_in;
  logic        ready_out;
  logic [3:0]  valid_out;
  logic [31:0] data_out;
  logic        ready_in;

  logic        flush4;
  logic [3:0]  valid_in4;
  logic [31:0] data_in4;
  logic        ready_out4;
  logic [3:0]  valid_out4;
  logic [31:0] data_out4;
  logic        ready_in4;

`ifdef FLOPS_PIPE_CNT_EN
  logic [15:0] beat_count;
  logic [15:0] beat_count4;
`endif

  always #5 clk_8f = ~clk_8f;

  flops_pipe_valid u_dut (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .flush     (flush),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out),
    .ready_in  (ready_in)
`ifdef FLOPS_PIPE_CNT_EN
    ,
    .beat_count(beat_count)
`endif
  );

  flops_pipe_valid #(.WIDTH(8), .LANES(4), .DEPTH(4)) u_dut4 (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .flush     (flush4),
    .valid_in  (valid_in4),
    .data_in   (data_in4),
    .ready_out (ready_out4),
    .valid_out (valid_out4),
    .data_out  (data_out4),
    .ready_in  (ready_in4)
`ifdef FLOPS_PIPE_CNT_EN
    ,
    .beat_count(beat_count4)
`endif
  );

  typedef struct packed {
    logic [3:0]  v;
    logic [31:0] d;
  } beat_t;

  beat_t sb[$];
  int    checks  = 0;
  int    errors  = 0;
  int    exp_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic rdy, input logic fl);
    valid_in = v;
    data_in  = d;
    ready_in = rdy;
    flush    = fl;
    #1;
  endtask

  // Scoreboard update for the cycle about to end, then advance one clock.
  task automatic tick();
    beat_t b;
    if (!reset) begin
      sb.delete();
      exp_cnt = 0;
    end else begin
      if (|valid_out && ready_in) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_out", 64'(valid_out), 64'(4'h0));
        end else begin
          b = sb.pop_front();
          check("sb_valid", 64'(valid_out), 64'(b.v));
          check("sb_data", 64'(data_out), 64'(b.d));
          exp_cnt++;
        end
      end
      if (flush) sb.delete();
      else if (|valid_in && ready_out) sb.push_back(beat_t'({valid_in, data_in}));
    end
    @(posedge clk_8f);
    @(negedge clk_8f);
  endtask

  task automatic check_count(input string tag);
`ifdef FLOPS_PIPE_CNT_EN
    check(tag, 64'(beat_count), 64'(exp_cnt[15:0]));
`endif
  endtask

  initial begin
    reset = 1'b0;
    flush4 = 1'b0; valid_in4 = '0; data_in4 = '0; ready_in4 = 1'b0;
    @(negedge clk_8f);
    drive(4'h0, 32'h0, 1'b1, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    drive(4'h0, 32'h0, 1'b1, 1'b0);
    check("rst_valid_out", 64'(valid_out), 64'(4'h0));
    check("rst_data_out", 64'(data_out), 64'(32'h0));
    check("rst_ready_out", 64'(ready_out), 64'(1'b1));
    check_count("rst_beat_count");

    // Two-cycle latency, single cycle of output
    drive(4'hF, 32'hA1B2C3D4, 1'b1, 1'b0);
    tick();
    drive(4'h0, 32'h0, 1'b1, 1'b0);
    check("lat_cyc11_valid", 64'(valid_out), 64'(4'h0));
    tick();
    check("lat_cyc12_valid", 64'(valid_out), 64'(4'hF));
    check("lat_cyc12_data", 64'(data_out), 64'(32'hA1B2C3D4));
    tick();
    check("lat_cyc13_valid", 64'(valid_out), 64'(4'h0));

    // Partial lanes followed by a bubble
    drive(4'b0101, 32'h11223344, 1'b1, 1'b0);
    tick();
    drive(4'h0, 32'hDEADBEEF, 1'b1, 1'b0);
    tick();
    drive(4'h0, 32'h0, 1'b1, 1'b0);
    check("part_valid", 64'(valid_out), 64'(4'b0101));
    check("part_data", 64'(data_out), 64'(32'h11223344));
    tick();
    check("bubble_no_out", 64'(valid_out), 64'(4'h0));
    tick();

    // Backpressure: third beat held until ready_in rises
    drive(4'hF, 32'h01, 1'b0, 1'b0);
    check("bp_rdy_beat1", 64'(ready_out), 64'(1'b1));
    tick();
    drive(4'hF, 32'h02, 1'b0, 1'b0);
    check("bp_rdy_beat2", 64'(ready_out), 64'(1'b1));
    tick();
    drive(4'hF, 32'h03, 1'b0, 1'b0);
    check("bp_rdy_full", 64'(ready_out), 64'(1'b0));
    check("bp_hold_data", 64'(data_out), 64'(32'h01));
    tick();
    check("bp_rdy_still_full", 64'(ready_out), 64'(1'b0));
    check("bp_hold_valid", 64'(valid_out), 64'(4'hF));
    tick();
    drive(4'hF, 32'h03, 1'b1, 1'b0);
    check("bp_rdy_full_drain", 64'(ready_out), 64'(1'b1));
    tick();
    drive(4'h0, 32'h0, 1'b1, 1'b0);
    check("bp_second_data", 64'(data_out), 64'(32'h02));
    tick();
    check("bp_third_data", 64'(data_out), 64'(32'h03));
    tick();
    check("bp_drained_valid", 64'(valid_out), 64'(4'h0));
    check("bp_sb_empty", 64'(sb.size()), 64'(0));
    check_count("bp_beat_count");

    // Back-to-back stream at full rate
    for (int i = 0; i < 6; i++) begin
      drive(4'($urandom_range(1, 15)), $urandom, 1'b1, 1'b0);
      check("tput_ready", 64'(ready_out), 64'(1'b1));
      tick();
    end
    drive(4'h0, 32'h0, 1'b1, 1'b0);
    repeat (2) tick();
    check("tput_sb_empty", 64'(sb.size()), 64'(0));

    // Flush with the pipe full and a beat waiting on the input
    drive(4'hF, 32'hAAAAAAAA, 1'b0, 1'b0);
    tick();
    drive(4'hF, 32'hBBBBBBBB, 1'b0, 1'b0);
    tick();
    drive(4'hF, 32'hCCCCCCCC, 1'b0, 1'b1);
    tick();
    drive(4'h0, 32'h0, 1'b1, 1'b0);
    check("flush_valid_out", 64'(valid_out), 64'(4'h0));
    check("flush_ready_out", 64'(ready_out), 64'(1'b1));
    check("flush_dat_kept", 64'(data_out), 64'(32'hAAAAAAAA));
    check_count("flush_beat_count");
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flush_nothing_emerges", 64'(valid_out), 64'(4'h0));
    end

    // Reset mid-stream with two beats stored
    drive(4'hF, 32'h55555555, 1'b0, 1'b0);
    tick();
    drive(4'h3, 32'h66666666, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    drive(4'h0, 32'h0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    drive(4'h0, 32'h0, 1'b0, 1'b0);
    check("mrst_valid_out", 64'(valid_out), 64'(4'h0));
    check("mrst_data_out", 64'(data_out), 64'(32'h0));
    check("mrst_ready_out", 64'(ready_out), 64'(1'b1));
    check_count("mrst_beat_count");

    // DEPTH=4 bubble collapse: beats on cycles 0, 3, 4, 5 with output stalled
    for (int c = 0; c < 6; c++) begin
      valid_in4 = (c == 0 || c >= 3) ? 4'hF : 4'h0;
      data_in4  = 32'h40 + 32'(c);
      #1;
      check("d4_ready_before_full", 64'(ready_out4), 64'(1'b1));
      tick();
    end
    valid_in4 = 4'h0;
    data_in4  = 32'h0;
    #1;
    check("d4_ready_full", 64'(ready_out4), 64'(1'b0));
    ready_in4 = 1'b1;
    #1;
    check("d4_ready_full_drain", 64'(ready_out4), 64'(1'b1));
    check("d4_out0_valid", 64'(valid_out4), 64'(4'hF));
    check("d4_out0_data", 64'(data_out4), 64'(32'h40));
    tick();
    check("d4_out1_data", 64'(data_out4), 64'(32'h43));
    tick();
    check("d4_out2_data", 64'(data_out4), 64'(32'h44));
    tick();
    check("d4_out3_data", 64'(data_out4), 64'(32'h45));
    check("d4_out3_valid", 64'(valid_out4), 64'(4'hF));
    tick();
    check("d4_drained", 64'(valid_out4), 64'(4'h0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
